// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store front end: access sizes, FSM states
// and the check that rejects illegal or misaligned requests.
package mem_access_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    DONE
  } state_e;

  // Halves must sit on an even byte and words on a word boundary.
  function automatic logic isBadAccess(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bus from the execute stage plus the word-addressed
// datamemory port; the unit takes the slave side.
interface mem_access_unit_if
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 14
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] mem_readAddr;
  logic [ADDR_W-1:0] mem_writeAddr;
  logic              mem_readEn;
  logic              mem_writeEn;
  logic [DATA_W-1:0] mem_dIn;
  logic [DATA_W-1:0] mem_dOut;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dOut,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_readAddr, mem_writeAddr, mem_readEn, mem_writeEn, mem_dIn
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dOut,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_readAddr, mem_writeAddr, mem_readEn, mem_writeEn, mem_dIn
  );

endinterface

// File: rtl/mem_access_unit_byte_lane_unit.sv
// Combinational lane logic: extracts and extends a load lane, and merges
// a sub-word store into the word read back from memory.
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        offset_i,
  input  size_e             size_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] loadData_o,
  output logic [DATA_W-1:0] storeData_o
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;

  // Half accesses only ever arrive with offset 0 or 2, so shamt is 0 or 16.
  always_comb begin
    shamt      = {offset_i, 3'b000};
    shifted    = word_i >> shamt;
    loadData_o = word_i;
    mask       = '1;
    case (size_i)
      SZ_BYTE: begin
        loadData_o = {{(DATA_W-8){signed_i & shifted[7]}}, shifted[7:0]};
        mask       = 32'h0000_00FF;
      end
      SZ_HALF: begin
        loadData_o = {{(DATA_W-16){signed_i & shifted[15]}}, shifted[15:0]};
        mask       = 32'h0000_FFFF;
      end
      default: ;
    endcase
    storeData_o = (word_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of datamemory: one request at a time,
// read-modify-write for sub-word stores, registered memory/response outputs.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  size_e             size_q, size_d;
  logic              signed_q, signed_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              readEn_q, readEn_d;
  logic              writeEn_q, writeEn_d;
  logic              respValid_q, respValid_d;
  logic              respErr_q, respErr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] dIn_q, dIn_d;

  logic              accept;
  logic              reqErr;
  size_e             reqSize;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] storeData;

  assign reqSize       = size_e'(bus.req_size);
  assign reqErr        = isBadAccess(reqSize, bus.req_addr[1:0]);
  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  byte_lane_unit u_lanes (
    .word_i      (bus.mem_dOut),
    .offset_i    (addr_q[1:0]),
    .size_i      (size_q),
    .signed_i    (signed_q),
    .wdata_i     (wdata_q),
    .loadData_o  (loadData),
    .storeData_o (storeData)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    signed_d  = signed_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    dIn_d     = dIn_q;
    rdata_d   = '0;
    respErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = bus.req_addr;
          size_d   = reqSize;
          signed_d = bus.req_signed;
          write_d  = bus.req_write;
          wdata_d  = bus.req_wdata;
          if (reqErr) begin
            state_d   = DONE;
            respErr_d = 1'b1;
          end else if (bus.req_write && reqSize == SZ_WORD) begin
            state_d = WRITE;
            dIn_d   = bus.req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        if (write_q) begin
          dIn_d   = storeData;
          state_d = WRITE;
        end else begin
          rdata_d = loadData;
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes are decoded from the next state so they come straight off flops.
    readEn_d    = (state_d == READ);
    writeEn_d   = (state_d == WRITE);
    respValid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      readEn_q    <= 1'b0;
      writeEn_q   <= 1'b0;
      respValid_q <= 1'b0;
      respErr_q   <= 1'b0;
      rdata_q     <= '0;
      dIn_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      readEn_q    <= readEn_d;
      writeEn_q   <= writeEn_d;
      respValid_q <= respValid_d;
      respErr_q   <= respErr_d;
      rdata_q     <= rdata_d;
      dIn_q       <= dIn_d;
    end
  end

  assign bus.mem_readAddr  = addr_q[ADDR_W+1:2];
  assign bus.mem_writeAddr = addr_q[ADDR_W+1:2];
  assign bus.mem_readEn    = readEn_q;
  assign bus.mem_writeEn   = writeEn_q;
  assign bus.mem_dIn       = dIn_q;
  assign bus.resp_valid    = respValid_q;
  assign bus.resp_err      = respErr_q;
  assign bus.resp_rdata    = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases followed by random requests,
// checked against a word-array reference of memory and the access rules.
module tb_mem_access_unit;

  localparam int ADDR_W = 14;

  logic clk = 1'b0;
  logic reset;
  logic preload;

  int testsRun    = 0;
  int testsFailed = 0;
  int rdCount     = 0;
  int wrCount     = 0;
  int respCount   = 0;
  int cycleCount  = 0;
  logic [ADDR_W-1:0] lastWrAddr = '0;
  logic keepValid = 1'b0;

  logic [31:0] mem    [0:(1<<ADDR_W)-1];
  logic [31:0] refMem [0:63];

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int i);
    return 32'hA5C3_0F1E ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Memory model: registered read data, write on the strobe edge.
  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
    end else begin
      if (bus.mem_readEn) bus.mem_dOut <= mem[bus.mem_readAddr];
      if (bus.mem_writeEn) begin
        mem[bus.mem_writeAddr] <= bus.mem_dIn;
        lastWrAddr             <= bus.mem_writeAddr;
      end
    end
    if (bus.mem_readEn)  rdCount   <= rdCount + 1;
    if (bus.mem_writeEn) wrCount   <= wrCount + 1;
    if (bus.resp_valid)  respCount <= respCount + 1;
  end

  function automatic logic [31:0] expectedLoad(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sg, input logic [1:0] off);
    logic [31:0] v;
    v = w >> (int'(off) * 8);
    if (sz == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                               input logic [15:0] a, input logic [31:0] wd, output int respAt);
    logic        expErr;
    logic [31:0] expData;
    logic [31:0] mask;
    int          expLat, lat, waitCyc, rd0, wr0, widx, sh;
    expErr  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    widx    = int'(a[7:2]);
    expData = '0;
    if (!expErr && !w) expData = expectedLoad(refMem[widx], sz, sg, a[1:0]);
    expLat  = expErr ? 1 : (w ? ((sz == 2'd2) ? 2 : 4) : 3);

    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    waitCyc = 0;
    while (bus.req_ready !== 1'b1 && waitCyc < 20) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    checkOutput("ready_before_accept", 32'(bus.req_ready), 32'd1);
    rd0 = rdCount;
    wr0 = wrCount;
    @(posedge clk); #1;
    if (!keepValid) begin
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'($urandom);
      bus.req_size   = 2'($urandom);
      bus.req_signed = 1'($urandom);
      bus.req_addr   = 16'($urandom);
      bus.req_wdata  = $urandom;
    end

    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 8) begin
      checkOutput("ready_busy", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    respAt = cycleCount;
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("resp_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("ready_done", 32'(bus.req_ready), 32'd0);
    checkOutput("resp_err", 32'(bus.resp_err), 32'(expErr));
    checkOutput("resp_rdata", bus.resp_rdata, expData);

    if (w && !expErr) begin
      mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      sh   = int'(a[1:0]) * 8;
      refMem[widx] = (refMem[widx] & ~(mask << sh)) | ((wd & mask) << sh);
      checkOutput("wr_addr", 32'(lastWrAddr), 32'(a[15:2]));
    end
    checkOutput("read_strobes", 32'(rdCount - rd0), (expErr || (w && sz == 2'd2)) ? 32'd0 : 32'd1);
    checkOutput("write_strobes", 32'(wrCount - wr0), (w && !expErr) ? 32'd1 : 32'd0);
    checkOutput("mem_word", mem[a[15:2]], refMem[widx]);

    @(posedge clk); #1;
    checkOutput("resp_pulse", 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0, r1, wr0, rsp0, waitCyc;
    logic        w, sg;
    logic [1:0]  sz;
    logic [15:0] a;

    for (int i = 0; i < 64; i++) refMem[i] = initWord(i);
    reset          = 1'b1;
    preload        = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("rst_resp_rdata", bus.resp_rdata, 32'd0);
    checkOutput("rst_readEn", 32'(bus.mem_readEn), 32'd0);
    checkOutput("rst_writeEn", 32'(bus.mem_writeEn), 32'd0);
    checkOutput("rst_dIn", bus.mem_dIn, 32'd0);
    checkOutput("rst_readAddr", 32'(bus.mem_readAddr), 32'd0);
    checkOutput("rst_writeAddr", 32'(bus.mem_writeAddr), 32'd0);
    preload = 1'b0;
    reset   = 1'b0;
    #1;
    checkOutput("ready_after_reset", 32'(bus.req_ready), 32'd1);

    // Directed sequence from the test plan.
    applyStimulus(1'b1, 2'd2, 1'b0, 16'h0010, 32'h8899_AABB, r0);
    checkOutput("sw_word", mem[4], 32'h8899_AABB);
    applyStimulus(1'b0, 2'd0, 1'b1, 16'h0011, 32'h0, r0);
    applyStimulus(1'b0, 2'd0, 1'b0, 16'h0011, 32'h0, r0);
    applyStimulus(1'b0, 2'd1, 1'b1, 16'h0012, 32'h0, r0);
    applyStimulus(1'b0, 2'd1, 1'b0, 16'h0012, 32'h0, r0);
    checkOutput("lh_model", expectedLoad(32'h8899_AABB, 2'd1, 1'b1, 2'd2), 32'hFFFF_8899);
    applyStimulus(1'b1, 2'd0, 1'b0, 16'h0013, 32'h0000_005A, r0);
    checkOutput("sb_word", mem[4], 32'h5A99_AABB);
    applyStimulus(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, r0);
    applyStimulus(1'b0, 2'd2, 1'b0, 16'h0012, 32'h0, r0);
    applyStimulus(1'b1, 2'd1, 1'b0, 16'h0011, 32'h0000_1234, r0);
    applyStimulus(1'b0, 2'd3, 1'b0, 16'h0010, 32'h0, r0);

    // Reset during the READ cycle of a sub-word store abandons it.
    wr0  = wrCount;
    rsp0 = respCount;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'd1;
    bus.req_signed = 1'b0;
    bus.req_addr   = 16'h0010;
    bus.req_wdata  = 32'h0000_1234;
    waitCyc = 0;
    while (bus.req_ready !== 1'b1 && waitCyc < 20) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkOutput("abort_readEn", 32'(bus.mem_readEn), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_ready_in_reset", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_ready_after", 32'(bus.req_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("abort_no_write", 32'(wrCount - wr0), 32'd0);
    checkOutput("abort_no_resp", 32'(respCount - rsp0), 32'd0);
    checkOutput("abort_mem_word", mem[4], 32'h5A99_AABB);

    // Back-to-back loads with req_valid held high.
    keepValid = 1'b1;
    applyStimulus(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, r0);
    applyStimulus(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0, r1);
    keepValid     = 1'b0;
    bus.req_valid = 1'b0;
    checkOutput("queued_spacing", 32'(r1 - r0), 32'd4);

    // Random traffic over a small window so stores and loads overlap.
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      a  = 16'($urandom_range(0, 255));
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      applyStimulus(w, sz, sg, a, $urandom, r0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end sitting directly upstream of `datamemory`: accepts byte-addressed load/store requests from the execute stage and drives the word-addressed `datamemory` port. Handles byte/halfword/word sizes, sign/zero extension, and read-modify-write for sub-word stores. Flags misaligned accesses instead of issuing them.

## Interface
- `ADDR_W`, 14: word-address width of `datamemory`; byte address is `ADDR_W+2` bits.
- `DATA_W`, 32: data width; fixed at 32, other values unsupported.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept; accept = `req_valid && req_ready` at a rising edge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  ADDR_W+2  byte address.
- `req_wdata`  in  32  store data; sub-word stores use low bits.
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_err`  out  1  valid with `resp_valid`: misaligned/illegal.
- `resp_rdata`  out  32  load result, valid with `resp_valid`; 0 for stores and errors.
- `mem_readAddr`, `mem_writeAddr`  out  ADDR_W  both = `req_addr[ADDR_W+1:2]`.
- `mem_readEn`, `mem_writeEn`  out  1  memory strobes.
- `mem_dIn`  out  32  write data to memory.
- `mem_dOut`  in  32  memory read data, valid the cycle after a `mem_readEn` cycle.

## Operation
- States: IDLE, READ, CAPTURE, WRITE, DONE. `req_ready` = 1 only in IDLE and reset not asserted.
- Accept in IDLE latches addr, size, signed, write, wdata:
  - error (size 11; half with addr[0]=1; word with addr[1:0]≠0) → DONE, `resp_err`=1, no memory strobes ever.
  - word store → WRITE.
  - load or sub-word store → READ.
- READ: `mem_readEn`=1 → CAPTURE.
- CAPTURE: sample `mem_dOut`.
  - load: extract lane, extend into `resp_rdata` register → DONE.
  - sub-word store: merge new byte/half into the word, register as `mem_dIn` → WRITE.
- WRITE: `mem_writeEn`=1 with `mem_dIn` → DONE.
- DONE: `resp_valid`=1 for exactly one cycle → IDLE.
- Little-endian lanes:
  - byte offset k → bits [8k+7:8k].
  - half offset 0 → [15:0]; half offset 2 → [31:16].
- Sub-word stores leave the other lanes unchanged.
- All memory-side outputs and response outputs are registered; none combinational from request inputs.

## Timing
- Latency, accept edge to `resp_valid` cycle:
  - error: 1 cycle.
  - word store: 2 cycles.
  - load: 3 cycles.
  - sub-word store: 4 cycles.
- No request overlap; the next accept is no earlier than the cycle after DONE (IDLE).
- Reset values: state IDLE; `req_ready`=0 while `reset` is high, 1 the first cycle after. All other outputs are 0 (`resp_valid`, `resp_err`, `resp_rdata`, all `mem_*`).
- Reset mid-operation abandons the request with no response.
  - A WRITE cycle already in progress when reset rises still commits, because `mem_writeEn` is a register already high.
  - Reset during READ/CAPTURE produces no write.
- `req_*` inputs are ignored outside the accept cycle.

## Structure
- Package `mem_access_pkg`: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, `DATA_W`.
- Sub-module `byte_lane_unit` (combinational): lane extract + sign/zero extend for loads; lane insert for stores. Instantiated once by the FSM module.

## Test plan
- sw 0x8899AABB @0x0010 → one `mem_writeEn` cycle, `mem_writeAddr`=4, `mem_dIn`=0x8899AABB; `resp_valid` 2 cycles after accept; `resp_err`=0.
- Sub-word loads, each with `resp_valid` 3 cycles after accept:
  - lb @0x0011 → 0xFFFFFFAA.
  - lbu @0x0011 → 0x000000AA.
  - lh @0x0012 → 0xFFFF8899.
  - lhu @0x0012 → 0x00008899.
- sb 0x5A @0x0013 → read then write of 0x5A99AABB at `mem_writeAddr`=4; following lw @0x0010 → 0x5A99AABB.
- lw @0x0012, sh @0x0011, size=11 → `resp_valid` 1 cycle after accept, `resp_err`=1, `resp_rdata`=0, no strobes.
- sh 0x1234 @0x0010, reset asserted in READ cycle → no `mem_writeEn`, no `resp_valid`; memory word unchanged; `req_ready`=1 first cycle after reset drops.
- `req_valid` held high with two queued loads → `req_ready` low from accept through DONE; second load accepted in the first IDLE cycle; responses spaced 4 cycles apart.
